// File: rtl/block_lock_ctrl.sv
// ============================================================================
// Module   : block_lock_ctrl
// Purpose  : 10GBASE-R 64b/66b block-lock controller. It checks sync headers,
//            drives the gearbox slip input and reports block lock.
//            Optional statistics counters are built when BLOCK_LOCK_STATS_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module block_lock_ctrl #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_HIGH    = 2,
    parameter int SLIP_WAIT    = 140,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic [1:0]       head_i,
    input  logic             head_valid_i,
    output logic             slip_o,
    output logic             block_lock_o,
    output logic [CNT_W-1:0] slip_cnt_o,
    output logic [CNT_W-1:0] lock_loss_cnt_o
);

    localparam int c_SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int c_WAIT_W = $clog2(((SLIP_WAIT > SLIP_HIGH) ? SLIP_WAIT : SLIP_HIGH) + 1);

    localparam logic [c_SH_W-1:0]   c_SH_LAST    = c_SH_W'(SH_CNT_MAX - 1);
    localparam logic [c_SH_W-1:0]   c_INVLD_LAST = c_SH_W'(SH_INVLD_MAX - 1);
    localparam logic [c_WAIT_W-1:0] c_HIGH_LAST  = c_WAIT_W'(SLIP_HIGH - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST  = c_WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        S_RESET_CNT = 2'd0,
        S_TEST_SH   = 2'd1,
        S_SLIP      = 2'd2,
        S_SLIP_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_slip;
    logic                r_block_lock;
    logic [c_SH_W-1:0]   r_sh_cnt;
    logic [c_SH_W-1:0]   r_sh_invld_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic w_hdr_invalid;
    logic w_hdr_evt;
    logic w_hit_invld_max;
    logic w_slip_entry;
    logic w_lock_drop;
    logic w_window_end;
    logic w_lock_gain;

    // 2'b01 and 2'b10 are the only legal sync headers
    assign w_hdr_invalid   = ~(head_i[1] ^ head_i[0]);
    assign w_hdr_evt       = enable_i && (r_state == S_TEST_SH) && head_valid_i;
    assign w_hit_invld_max = w_hdr_invalid && (r_sh_invld_cnt == c_INVLD_LAST);
    assign w_slip_entry    = w_hdr_evt && w_hdr_invalid && (!r_block_lock || w_hit_invld_max);
    assign w_lock_drop     = r_block_lock && (!enable_i || (w_hdr_evt && w_hit_invld_max));
    assign w_window_end    = w_hdr_evt && (r_sh_cnt == c_SH_LAST);
    assign w_lock_gain     = w_window_end && !w_hdr_invalid && (r_sh_invld_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state        <= S_RESET_CNT;
            r_slip         <= 1'b0;
            r_block_lock   <= 1'b0;
            r_sh_cnt       <= '0;
            r_sh_invld_cnt <= '0;
            r_wait_cnt     <= '0;
        end else begin
            if (w_lock_drop) begin
                r_block_lock <= 1'b0;
            end else if (w_lock_gain) begin
                r_block_lock <= 1'b1;
            end

            if (!enable_i) begin
                r_state        <= S_RESET_CNT;
                r_slip         <= 1'b0;
                r_sh_cnt       <= '0;
                r_sh_invld_cnt <= '0;
                r_wait_cnt     <= '0;
            end else begin
                case (r_state)
                    S_RESET_CNT: begin
                        r_sh_cnt       <= '0;
                        r_sh_invld_cnt <= '0;
                        r_wait_cnt     <= '0;
                        r_state        <= S_TEST_SH;
                    end
                    S_TEST_SH: begin
                        if (head_valid_i) begin
                            // slip outranks the end-of-window decision
                            if (w_slip_entry) begin
                                r_slip     <= 1'b1;
                                r_wait_cnt <= '0;
                                r_state    <= S_SLIP;
                            end else if (w_window_end) begin
                                r_state <= S_RESET_CNT;
                            end else begin
                                r_sh_cnt       <= r_sh_cnt + c_SH_W'(1);
                                r_sh_invld_cnt <= r_sh_invld_cnt + c_SH_W'(w_hdr_invalid);
                            end
                        end
                    end
                    S_SLIP: begin
                        if (r_wait_cnt == c_HIGH_LAST) begin
                            r_slip     <= 1'b0;
                            r_wait_cnt <= '0;
                            r_state    <= S_SLIP_WAIT;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                        end
                    end
                    S_SLIP_WAIT: begin
                        // headers are still misaligned while the gearbox shifts
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            r_wait_cnt <= '0;
                            r_state    <= S_RESET_CNT;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                        end
                    end
                    default: begin
                        r_slip  <= 1'b0;
                        r_state <= S_RESET_CNT;
                    end
                endcase
            end
        end
    end

    assign slip_o       = r_slip;
    assign block_lock_o = r_block_lock;

`ifdef BLOCK_LOCK_STATS_EN
    logic [CNT_W-1:0] r_slip_cnt;
    logic [CNT_W-1:0] r_lock_loss_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_slip_cnt      <= '0;
            r_lock_loss_cnt <= '0;
        end else begin
            if (w_slip_entry && !(&r_slip_cnt)) begin
                r_slip_cnt <= r_slip_cnt + CNT_W'(1);
            end
            if (w_lock_drop && !(&r_lock_loss_cnt)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + CNT_W'(1);
            end
        end
    end

    assign slip_cnt_o      = r_slip_cnt;
    assign lock_loss_cnt_o = r_lock_loss_cnt;
`else
    assign slip_cnt_o      = '0;
    assign lock_loss_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_lock_ctrl.sv
// ============================================================================
// Module   : tb_block_lock_ctrl
// Purpose  : Directed self-checking bench for block_lock_ctrl (stats counters
//            4 bits wide so saturation is reachable).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_block_lock_ctrl;

`ifdef BLOCK_LOCK_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       enable_i;
    logic [1:0] head_i;
    logic       head_valid_i;
    logic       slip_o;
    logic       block_lock_o;
    logic [3:0] slip_cnt_o;
    logic [3:0] lock_loss_cnt_o;

    int n_pass  = 0;
    int n_total = 0;
    int slip_hits;
    int lock_low;

    block_lock_ctrl #(
        .CNT_W (4)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .enable_i        (enable_i),
        .head_i          (head_i),
        .head_valid_i    (head_valid_i),
        .slip_o          (slip_o),
        .block_lock_o    (block_lock_o),
        .slip_cnt_o      (slip_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] st(input int v);
        return c_STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [1:0] h);
        head_i       = h;
        head_valid_i = 1'b1;
        tick();
        head_valid_i = 1'b0;
        head_i       = 2'b00;
    endtask

    // 64 good headers on alternate cycles; lock must rise right after the 64th
    task automatic acquire(input string tag);
        slip_hits = 0;
        for (int i = 0; i < 63; i++) begin
            send(2'b01);
            slip_hits += int'(slip_o);
            tick();
            slip_hits += int'(slip_o);
        end
        chk({tag, "_lock_before_64"}, block_lock_o, 0);
        send(2'b01);
        chk({tag, "_lock_after_64"}, block_lock_o, 1);
        chk({tag, "_no_slip"}, slip_hits + int'(slip_o), 0);
        tick();
    endtask

    // slip pulse then the ignore window, fed with bad headers throughout
    task automatic slip_and_wait(input string tag);
        tick();
        chk({tag, "_slip_cycle2"}, slip_o, 1);
        tick();
        chk({tag, "_slip_low"}, slip_o, 0);
        slip_hits    = 0;
        head_i       = 2'b11;
        head_valid_i = 1'b1;
        repeat (140) begin
            tick();
            slip_hits += int'(slip_o);
        end
        head_valid_i = 1'b0;
        tick();
        chk({tag, "_ignored_hdrs"}, slip_hits, 0);
    endtask

    initial begin
        rst_n_i      = 1'b0;
        enable_i     = 1'b0;
        head_i       = 2'b00;
        head_valid_i = 1'b0;
        repeat (3) tick();
        chk("rst_slip", slip_o, 0);
        chk("rst_lock", block_lock_o, 0);
        chk("rst_slip_cnt", slip_cnt_o, 0);
        chk("rst_loss_cnt", lock_loss_cnt_o, 0);

        rst_n_i = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();

        // search: third header invalid while unlocked
        send(2'b01);
        tick();
        send(2'b10);
        tick();
        send(2'b11);
        chk("t3_slip_rise", slip_o, 1);
        chk("t3_lock", block_lock_o, 0);
        chk("t3_slip_cnt", slip_cnt_o, st(1));
        slip_and_wait("t3");
        acquire("t3_acq");
        chk("t3_slip_cnt_after", slip_cnt_o, st(1));

        // tolerate: 15 invalid headers, the last one being the 64th
        slip_hits = 0;
        lock_low  = 0;
        for (int i = 1; i <= 64; i++) begin
            send((i >= 50) ? 2'b11 : 2'b01);
            slip_hits += int'(slip_o);
            lock_low  += int'(!block_lock_o);
            tick();
        end
        chk("t4_w1_no_slip", slip_hits, 0);
        chk("t4_w1_lock_held", lock_low, 0);

        // 16 invalid headers in the next window drop the lock
        slip_hits = 0;
        lock_low  = 0;
        for (int i = 1; i <= 15; i++) begin
            send(2'b11);
            slip_hits += int'(slip_o);
            lock_low  += int'(!block_lock_o);
            tick();
        end
        chk("t4_w2_15_no_slip", slip_hits, 0);
        chk("t4_w2_15_lock_held", lock_low, 0);
        send(2'b11);
        chk("t4_16th_lock", block_lock_o, 0);
        chk("t4_16th_slip", slip_o, 1);
        chk("t4_loss_cnt", lock_loss_cnt_o, st(1));
        chk("t4_slip_cnt", slip_cnt_o, st(2));
        slip_and_wait("t4");
        acquire("t4_acq");

        // disable for one cycle while locked
        enable_i = 1'b0;
        tick();
        chk("t5_lock_drop", block_lock_o, 0);
        chk("t5_slip", slip_o, 0);
        chk("t5_loss_cnt", lock_loss_cnt_o, st(2));
        enable_i = 1'b1;
        tick();
        acquire("t5_acq");

        // async reset in the middle of a slip pulse
        enable_i = 1'b0;
        tick();
        chk("t1_loss_cnt", lock_loss_cnt_o, st(3));
        enable_i = 1'b1;
        tick();
        send(2'b11);
        chk("t1_slip_rise", slip_o, 1);
        chk("t1_slip_cnt", slip_cnt_o, st(3));
        tick();
        chk("t1_slip_mid", slip_o, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t1_rst_slip", slip_o, 0);
        chk("t1_rst_lock", block_lock_o, 0);
        chk("t1_rst_slip_cnt", slip_cnt_o, 0);
        chk("t1_rst_loss_cnt", lock_loss_cnt_o, 0);
        tick();
        rst_n_i = 1'b1;
        tick();
        chk("t1_post_rst_slip", slip_o, 0);
        acquire("t1_acq");

        // no slip while disabled, then saturation of the slip counter
        enable_i     = 1'b0;
        head_i       = 2'b11;
        head_valid_i = 1'b1;
        slip_hits    = 0;
        repeat (3) begin
            tick();
            slip_hits += int'(slip_o);
        end
        head_valid_i = 1'b0;
        chk("t6_no_slip_disabled", slip_hits, 0);
        chk("t6_loss_cnt", lock_loss_cnt_o, st(1));
        enable_i = 1'b1;
        tick();
        slip_hits = 0;
        for (int k = 0; k < 20; k++) begin
            send(2'b11);
            slip_hits += int'(slip_o);
            repeat (145) tick();
        end
        chk("t6_slip_count", slip_hits, 20);
        chk("t6_slip_cnt_sat", slip_cnt_o, st(15));
        chk("t6_lock", block_lock_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
